// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: N-digit multiplexed 7-segment scanner with write-addressable digit buffer,
// PWM brightness, per-digit blink and leading-zero blanking; all pin outputs registered.
module seg7_scan_ctrl #(
    parameter int N_DIGIT        = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int DIM_BITS       = 3,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [$clog2(N_DIGIT)-1:0] i_wr_addr,
    input  logic [3:0]                 i_wr_data,
    input  logic                       i_wr_dp,
    input  logic [N_DIGIT-1:0]         i_blink_mask,
    input  logic                       i_lzb,
    input  logic [DIM_BITS-1:0]        i_bright,
    output logic [7:0]                 o_seg_d,
    output logic [N_DIGIT-1:0]         o_seg_com,
    output logic                       o_frame_tick
);
    localparam int AW = $clog2(N_DIGIT);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [111:0] HEX_LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic [3:0]         r_nib [N_DIGIT];
    logic [N_DIGIT-1:0] r_dp;
    logic [CW-1:0]      r_div_cnt;
    logic [AW-1:0]      r_digit_idx;
    logic [FW-1:0]      r_frame_cnt;
    logic               r_blink_phase;

    logic               w_div_tc, w_last, w_frame_tc, w_on, w_blank, w_zrun;
    logic [31:0]        w_thresh;
    logic [3:0]         w_nib;
    logic [N_DIGIT-1:0] w_lz, w_com;
    logic [7:0]         w_seg;

    assign w_div_tc   = r_div_cnt == CW'(SCAN_DIV - 1);
    assign w_last     = r_digit_idx == AW'(N_DIGIT - 1);
    assign w_frame_tc = r_frame_cnt == FW'(BLINK_FRAMES - 1);
    assign w_thresh   = (32'(i_bright) + 32'd1) * 32'(SCAN_DIV >> DIM_BITS);
    assign w_on       = (32'(r_div_cnt) < w_thresh) && !(r_blink_phase && i_blink_mask[r_digit_idx]);
    assign w_nib      = r_nib[r_digit_idx];
    assign w_blank    = i_lzb && (r_digit_idx != '0) && w_lz[r_digit_idx];
    assign w_seg      = {r_dp[r_digit_idx], w_blank ? 7'h00 : HEX_LUT[32'(w_nib) * 7 +: 7]};
    assign w_com      = w_on ? (N_DIGIT'(1) << r_digit_idx) : '0;

    // w_lz[i]: every nibble from digit i up to the most significant one is zero
    always_comb begin
        w_lz   = '0;
        w_zrun = 1'b1;
        for (int i = N_DIGIT - 1; i >= 0; i--) begin
            w_zrun  = w_zrun && (r_nib[i] == 4'h0);
            w_lz[i] = w_zrun;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_DIGIT; i++) r_nib[i] <= 4'h0;
            r_dp          <= '0;
            r_div_cnt     <= '0;
            r_digit_idx   <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            o_seg_d       <= {8{SEG_ACTIVE_LOW}};
            o_seg_com     <= {N_DIGIT{COM_ACTIVE_LOW}};
            o_frame_tick  <= 1'b0;
        end else begin
            if (i_wr_en && (32'(i_wr_addr) < N_DIGIT)) begin
                r_nib[i_wr_addr] <= i_wr_data;
                r_dp[i_wr_addr]  <= i_wr_dp;
            end
            if (w_div_tc) begin
                r_div_cnt   <= '0;
                r_digit_idx <= w_last ? '0 : r_digit_idx + 1'b1;
                if (w_last) begin
                    r_frame_cnt <= w_frame_tc ? '0 : r_frame_cnt + 1'b1;
                    if (w_frame_tc) r_blink_phase <= ~r_blink_phase;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            o_seg_d      <= w_seg ^ {8{SEG_ACTIVE_LOW}};
            o_seg_com    <= w_com ^ {N_DIGIT{COM_ACTIVE_LOW}};
            o_frame_tick <= (r_div_cnt == '0) && (r_digit_idx == '0);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random and directed stimulus against a cycle-count based reference of the
// scanner (slot/digit/frame derived arithmetically from cycles since reset).
module tb_seg7_scan_ctrl;
    localparam int N = 4, SD = 8, DB = 3, BF = 2;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_dp = 1'b0, lzb = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [3:0]    wr_data = '0;
    logic [N-1:0]  mask = '0;
    logic [DB-1:0] bright = '0;
    logic [7:0]    seg;
    logic [N-1:0]  com;
    logic          tick;

    int            n_checks = 0, n_errors = 0;
    int            cyc = 0;
    logic [4:0]    mbuf [N];
    logic [7:0]    exp_seg;
    logic [N-1:0]  exp_com;
    logic          exp_tick;

    seg7_scan_ctrl #(.N_DIGIT(N), .SCAN_DIV(SD), .DIM_BITS(DB), .BLINK_FRAMES(BF),
                     .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_dp(wr_dp), .i_blink_mask(mask), .i_lzb(lzb), .i_bright(bright),
        .o_seg_d(seg), .o_seg_com(com), .o_frame_tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < N; i++) mbuf[i] = 5'h0;
    endtask

    // Expected outputs for the edge that ends cycle 'cyc', from state before that edge's write.
    task automatic predict();
        int  dig, slot_pos, frame;
        bit  phase, lit, allz, blank;
        slot_pos = cyc % SD;
        dig      = (cyc / SD) % N;
        frame    = cyc / (SD * N);
        phase    = ((frame / BF) % 2) == 1;
        lit      = (slot_pos < (int'(bright) + 1) * (SD >> DB)) && !(phase && mask[dig]);
        allz     = 1'b1;
        for (int i = dig; i < N; i++) allz &= (mbuf[i][3:0] == 4'h0);
        blank    = lzb && dig > 0 && allz;
        exp_seg  = ~{mbuf[dig][4], blank ? 7'h00 : HEX[mbuf[dig][3:0]]};
        exp_com  = lit ? ~(N'(1) << dig) : {N{1'b1}};
        exp_tick = (cyc % (SD * N)) == 0;
    endtask

    task automatic step(input bit rnd);
        if (rnd) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 2'($urandom);
            wr_data = ($urandom % 2) ? 4'h0 : 4'($urandom);
            wr_dp   = 1'($urandom);
            bright  = DB'($urandom);
            if ($urandom % 64 == 0) mask = N'($urandom);
            if ($urandom % 64 == 0) lzb = 1'($urandom);
        end
        predict();
        if (wr_en) mbuf[wr_addr] = {wr_dp, wr_data};
        cyc++;
        @(posedge clk);
        #1;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("com", 32'(com), 32'(exp_com));
        chk("tick", 32'(tick), 32'(exp_tick));
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) step(rnd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
        step(1'b0);
        wr_en = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_com", 32'(com), 32'hF);
        chk("rst_tick", 32'(tick), 32'h0);
        bright = 3'd7;
        rst = 1'b0;
        step(1'b0);
        chk("rel_com", 32'(com), 32'hE);
        chk("rel_seg", 32'(seg), 32'hC0);
        run(15, 1'b0);
        wr(2'd2, 4'hA, 1'b1);
        run(40, 1'b0);
        wr(2'd2, 4'h0, 1'b0);
        wr(2'd0, 4'h5, 1'b0);
        lzb = 1'b1;
        run(40, 1'b0);
        lzb = 1'b0;
        run(40, 1'b0);
        foreach (HEX[v]) begin
            bright = DB'(v);
            run(8, 1'b0);
        end
        bright = 3'd7;
        mask = 4'b0010;
        run(200, 1'b0);
        mask = 4'b0000;
        run(2000, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("arst_seg", 32'(seg), 32'hFF);
        chk("arst_com", 32'(com), 32'hF);
        chk("arst_tick", 32'(tick), 32'h0);
        rst = 1'b0;
        model_reset();
        bright = 3'd0;
        mask = 4'b0000;
        step(1'b0);
        chk("restart_com", 32'(com), 32'hE);
        run(1000, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
